// File: rtl/sn74xxxx_pkg.sv
// Shared definitions for the 74xx counter family: direction encodings and the
// wrap-rule successor function reused by the presettable and up/down models.
package sn74xxxx_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Successor of q under the modulus wrap rules. Values at or above the
  // terminal count return to 0 going up; going down they decrement normally.
  function automatic logic [31:0] next_count(input logic [31:0]       q,
                                             input logic              dir,
                                             input longint unsigned   modulus);
    logic [63:0] q_ext;
    logic [63:0] res;
    q_ext = {32'd0, q};
    if (dir == DIR_DOWN) begin
      res = (q_ext == 64'd0) ? (modulus - 64'd1) : (q_ext - 64'd1);
    end else begin
      res = (q_ext >= (modulus - 64'd1)) ? 64'd0 : (q_ext + 64'd1);
    end
    return res[31:0];
  endfunction

endpackage

// File: rtl/counter_tc_detect.sv
// Terminal-count detection and ripple carry out, purely combinational.
// Macro COUNTER_7416X_UPDOWN_EN makes the terminal count depend on DIR.
module counter_tc_detect
  import sn74xxxx_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] Q,
  input  logic             DIR,
  input  logic             ENT,
  output logic             RCO
);

  logic [63:0] q_ext;
  logic        tc_up;
  logic        tc;

  assign q_ext = 64'(Q);
  assign tc_up = (q_ext == (MODULUS - 64'd1));

`ifdef COUNTER_7416X_UPDOWN_EN
  assign tc = (DIR == DIR_DOWN) ? (Q == '0) : tc_up;
`else
  // Up-only build: DIR is accepted on the port but has no effect.
  logic unused_dir;
  assign unused_dir = DIR;
  assign tc         = tc_up;
`endif

  // ENP deliberately does not gate the carry, so stages can ripple-cascade.
  assign RCO = ENT & tc;

endmodule

// File: rtl/counter_7416x.sv
// Parametrised synchronous presettable counter (74160/74161/74163 family).
// Optional up/down counting is enabled by defining COUNTER_7416X_UPDOWN_EN.
module counter_7416x
  import sn74xxxx_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  // Simulation-only Q delay of the behavioural models; no effect on this RTL.
  parameter int              DELAY   = 1
) (
  input  logic             C,
  input  logic             nR,
  input  logic             nCLR,
  input  logic             nLOAD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             DIR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  if ((WIDTH < 1) || (WIDTH > 32) || (MODULUS < 64'd2) ||
      (MODULUS > (64'd1 << WIDTH)) || (DELAY < 0)) begin : g_bad_params
    $error("counter_7416x: illegal WIDTH/MODULUS/DELAY combination");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             dir_eff;

`ifdef COUNTER_7416X_UPDOWN_EN
  assign dir_eff = DIR;
`else
  assign dir_eff = DIR_UP;
`endif

  // Clear beats load, load beats count; anything else holds.
  always_comb begin
    count_d = count_q;
    if (!nCLR) begin
      count_d = '0;
    end else if (!nLOAD) begin
      count_d = D;
    end else if (ENP && ENT) begin
      count_d = WIDTH'(next_count(32'(count_q), dir_eff, MODULUS));
    end
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q = count_q;

  counter_tc_detect #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .Q   (count_q),
    .DIR (DIR),
    .ENT (ENT),
    .RCO (RCO)
  );

endmodule
